rx_data_arbiter: RTL and testbench
==================================

// Module: rx_data_arbiter
// PURPOSE
//  Parametrised, buffered successor of the receive-data selector. Merges NCH
//  serial-receiver byte streams (uart/i2c/spi/...) into one registered output
//  stream with a valid/ready handshake. Each channel has its own FIFO, so no
//  byte is lost while another channel is being drained. Supports fixed-select
//  and round-robin modes. Sits between the receiver cores and the downstream
//  data divider/consumer.
// PARAMETERS
//  NCH       3      number of receive channels (>=2)
//  DW        8      data width per channel
//  DEPTH     4      per-channel FIFO depth; power of 2, >=2
//  RST_DATA  'h01   reset value of out_data_o (DW bits)
// PORTS
//  clk_i        in   1            clock, rising edge
//  rst_n        in   1            asynchronous, active-low reset
//  mode_i       in   1            0 = fixed select, 1 = round-robin
//  sel_i        in   CW=$clog2(NCH)  channel drained in fixed mode
//  ch_data_i    in   NCH*DW       channel k data at [k*DW +: DW]
//  ch_done_i    in   NCH          1-cycle receive-done strobe per channel
//  out_data_o   out  DW           registered output data
//  out_ch_o     out  CW           source channel of out_data_o
//  out_valid_o  out  1            out_data_o/out_ch_o valid
//  out_ready_i  in   1            consumer accepts when valid&ready
//  ovf_o        out  NCH          sticky per-channel overflow flag
//  ovf_clr_i    in   1            clears all ovf_o bits
// BEHAVIOUR
//  Reset: out_data_o=RST_DATA, out_ch_o=0, out_valid_o=0, ovf_o=0.
//   All FIFOs are empty. The RR pointer = NCH-1, so the first RR grant goes
//   to ch0. Reset mid-transfer discards all buffered data immediately.
//  Push: ch_done_i[k]=1 at edge t writes ch_data_i[k] into FIFO k. Pushes
//   are accepted in both modes, for all channels, every cycle.
//  Full: a push to a full FIFO with no same-cycle pop is dropped, and
//   ovf_o[k] is set. A push and pop on a full FIFO in the same cycle are
//   both performed, with no overflow.
//  Output stage is "free" when out_valid_o=0, or out_valid_o&out_ready_i.
//   When free and a grant exists, the stage loads the FIFO head and pops it.
//   It also sets out_valid_o=1 and out_ch_o=granted channel.
//   When free with no grant, out_valid_o goes 0 and out_data_o holds.
//  Latency: push at edge t -> out_valid_o=1 after edge t+1 (stage free, won).
//   Throughput: 1 word/cycle while out_ready_i=1.
//  Stall: out_valid_o=1 & out_ready_i=0 holds out_data_o, out_ch_o and
//   out_valid_o stable; no pops occur.
//  Fixed mode: grant = sel_i if FIFO[sel_i] non-empty, else none.
//   sel_i>=NCH -> never granted.
//  RR mode: search from ptr+1 (mod NCH) upward. The first non-empty channel
//   wins, and ptr takes its value on a load. ptr only updates on a load.
//  Mode or sel_i changes take effect at the next load. The word already in
//   the output stage is unaffected. ptr is retained across mode changes.
//  ovf_o: ovf_clr_i=1 clears all bits. If an overflow and the clear occur in
//   the same cycle, set wins for that channel.
//  FIFO pointers: CW'=$clog2(DEPTH)+1 bits; wrap-around by natural overflow;
//   full = MSB differ & rest equal.
// STRUCTURE
//  Package rx_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1 and the default DW.
//  Sub-module rx_chan_fifo (DW, DEPTH): synchronous FIFO with push, pop,
//   dout (head, combinational), empty and full. Instantiated NCH times via
//   generate.
//  Top: generate block, RR/fixed grant logic, output register, ovf flags.
// TESTING
//  1 Reset: out_data_o=8'h01, out_valid_o=0, ovf_o=0; release; idle for
//    10 cycles -> outputs unchanged.
//  2 Fixed, sel_i=1, ready=1: push 8'hA5 on ch1 at t -> after t+1:
//    out_valid_o=1, out_data_o=8'hA5, out_ch_o=1. A ch0 push 8'h11 is
//    buffered but never output until sel_i=0.
//  3 RR, ready=1: ch0,ch1,ch2 each receive 2 bytes (00,01/10,11/20,21) in
//    the same cycles. Output order must be 00,10,20,01,11,21 with
//    out_ch 0,1,2,0,1,2.
//  4 Overflow: ready=0; 5 pushes into ch2 (DEPTH=4).
//    Expect ovf_o=3'b100. Then ready=1 -> first 4 bytes plus the stalled
//    output word emerge in order; the 5th byte is absent.
//    ovf_clr_i -> ovf_o=0.
//  5 Full with simultaneous push/pop: ch0 full, ready=1, push in the same
//    cycle as a pop -> no ovf, byte delivered later. Stall check: ready=0
//    for 3 cycles -> data/ch stable.
//  6 Reset mid-stream: assert rst_n=0 with 3 bytes buffered ->
//    out_valid_o=0 at once; after release no stale bytes are output.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared constants for the receive-data arbiter: mode encodings and default width.
package rx_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   RX_DW      = 8;

  // Channel reached by stepping `step` places past `base` in an n-entry ring.
  function automatic int ring_idx(input int base, input int step, input int n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/rx_chan_fifo.sv
// Per-channel synchronous FIFO. The head is read combinationally.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module rx_chan_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // When the FIFO is full, a push is still accepted if the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rx_data_arbiter.sv
// Merges NCH buffered receiver byte streams into one registered valid/ready stream.
// It supports fixed-select and round-robin grant modes.
module rx_data_arbiter
  import rx_pkg::*;
#(
  parameter int            NCH      = 3,
  parameter int            DW       = RX_DW,
  parameter int            DEPTH    = 4,
  parameter logic [DW-1:0] RST_DATA = 'h01,
  localparam int           CW       = $clog2(NCH)
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              mode_i,
  input  logic [CW-1:0]     sel_i,
  input  logic [NCH*DW-1:0] ch_data_i,
  input  logic [NCH-1:0]    ch_done_i,
  output logic [DW-1:0]     out_data_o,
  output logic [CW-1:0]     out_ch_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [NCH-1:0]    ovf_o,
  input  logic              ovf_clr_i
);

  logic [NCH-1:0] empty;
  logic [NCH-1:0] full;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] ovf_set;
  logic [DW-1:0]  head [NCH];

  logic           gnt_vld;
  logic [CW-1:0]  gnt;
  logic [DW-1:0]  gnt_data;
  logic           free;
  logic           load;
  logic [CW-1:0]  ptr;
  int             idx;

  logic [DW-1:0]  data_p0;
  logic [CW-1:0]  ch_p0;
  logic           vld_p0;
  logic [NCH-1:0] ovf;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    rx_chan_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .push  (ch_done_i[k]),
      .pop   (pop[k]),
      .din   (ch_data_i[k*DW +: DW]),
      .dout  (head[k]),
      .empty (empty[k]),
      .full  (full[k])
    );

    assign pop[k]     = load & (gnt == CW'(k));
    assign ovf_set[k] = ch_done_i[k] & full[k] & ~pop[k];
  end

  // The round-robin search runs from the farthest channel to the nearest, so the nearest non-empty channel is assigned last and wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt      = '0;
    gnt_data = '0;
    idx      = 0;
    if (mode_i == MODE_FIXED) begin
      for (int k = 0; k < NCH; k++) begin
        if ((int'(sel_i) == k) && !empty[k]) begin
          gnt_vld  = 1'b1;
          gnt      = CW'(k);
          gnt_data = head[k];
        end
      end
    end else begin
      for (int i = NCH; i >= 1; i--) begin
        idx = ring_idx(int'(ptr), i, NCH);
        if (!empty[idx]) begin
          gnt_vld  = 1'b1;
          gnt      = CW'(idx);
          gnt_data = head[idx];
        end
      end
    end
  end

  assign free = ~vld_p0 | out_ready_i;
  assign load = free & gnt_vld;

  // Stage p0: output register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      data_p0 <= RST_DATA;
      ch_p0   <= '0;
      vld_p0  <= 1'b0;
    end else if (free) begin
      vld_p0 <= gnt_vld;
      if (gnt_vld) begin
        data_p0 <= gnt_data;
        ch_p0   <= gnt;
      end
    end
  end

  // The pointer moves only on round-robin loads, so fixed-mode traffic leaves the rotation where it was.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= CW'(NCH - 1);
    end else if (load && (mode_i == MODE_RR)) begin
      ptr <= gnt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= '0;
    end else begin
      ovf <= (ovf & ~{NCH{ovf_clr_i}}) | ovf_set;
    end
  end

  assign out_data_o  = data_p0;
  assign out_ch_o    = ch_p0;
  assign out_valid_o = vld_p0;
  assign ovf_o       = ovf;

endmodule

// File: tb/tb_rx_data_arbiter.sv
// Directed bench for rx_data_arbiter (NCH=3, DW=8, DEPTH=4): a vector table for
// fixed/RR ordering, plus hand sequences for overflow, full push+pop, stall and reset.
module tb_rx_data_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [23:0] ch_data;
  logic [2:0]  ch_done;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  ovf;
  logic        ovf_clr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [2:0] done;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [1:0] exp_ch;
  } vec_t;

  vec_t vecs[$];

  rx_data_arbiter #(
    .NCH      (3),
    .DW       (8),
    .DEPTH    (4),
    .RST_DATA (8'h01)
  ) dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .mode_i      (mode),
    .sel_i       (sel),
    .ch_data_i   (ch_data),
    .ch_done_i   (ch_done),
    .out_data_o  (out_data),
    .out_ch_o    (out_ch),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .ovf_o       (ovf),
    .ovf_clr_i   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic v, input logic [7:0] d, input logic [1:0] c);
    check({name, " valid"}, 32'(out_valid), 32'(v));
    check({name, " data"}, 32'(out_data), 32'(d));
    if (v) check({name, " ch"}, 32'(out_ch), 32'(c));
  endtask

  // Drives a one-cycle strobe on channel ch with byte b, then releases the strobes.
  task automatic push_tick(input int ch, input logic [7:0] b);
    ch_data = '0;
    ch_data[ch*8 +: 8] = b;
    ch_done = 3'b000;
    ch_done[ch] = 1'b1;
    tick();
    ch_done = 3'b000;
  endtask

  task automatic add(input logic m, input logic [1:0] s, input logic [2:0] dn,
                     input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                     input logic ev, input logic [7:0] ed, input logic [1:0] ec);
    vecs.push_back('{m, s, dn, a0, a1, a2, ev, ed, ec});
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd1;
    ch_data   = '0;
    ch_done   = '0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;

    // Fixed mode, sel=1: ch1 byte appears one cycle after its push; a ch0 byte waits for sel=0.
    add(0, 1, 3'b010, 8'h00, 8'hA5, 8'h00, 0, 8'h01, 0);
    add(0, 1, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'hA5, 1);
    add(0, 1, 3'b001, 8'h11, 8'h00, 8'h00, 0, 8'hA5, 0);
    add(0, 1, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'hA5, 0);
    add(0, 1, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'hA5, 0);
    add(0, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'h11, 0);
    add(0, 0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'h11, 0);
    // Round-robin: two bytes per channel arriving together drain interleaved.
    add(1, 0, 3'b111, 8'h00, 8'h10, 8'h20, 0, 8'h11, 0);
    add(1, 0, 3'b111, 8'h01, 8'h11, 8'h21, 1, 8'h00, 0);
    add(1, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'h10, 1);
    add(1, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'h20, 2);
    add(1, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'h01, 0);
    add(1, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'h11, 1);
    add(1, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'h21, 2);
    add(1, 0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'h21, 0);
    // Fixed mode with an out-of-range select never grants.
    add(0, 3, 3'b001, 8'h77, 8'h00, 8'h00, 0, 8'h21, 0);
    add(0, 3, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'h21, 0);
    add(0, 3, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'h21, 0);
    add(0, 0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'h77, 0);
    add(0, 0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'h77, 0);

    // Reset state
    tick();
    tick();
    expect_out("reset", 1'b0, 8'h01, 2'd0);
    check("reset ch", 32'(out_ch), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    expect_out("idle", 1'b0, 8'h01, 2'd0);
    check("idle ovf", 32'(ovf), 32'd0);

    // Vector table
    out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      mode    = vecs[i].mode;
      sel     = vecs[i].sel;
      ch_done = vecs[i].done;
      ch_data = {vecs[i].d2, vecs[i].d1, vecs[i].d0};
      tick();
      ch_done = 3'b000;
      expect_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_ch);
      check($sformatf("vec%0d ovf", i), 32'(ovf), 32'd0);
    end

    // Overflow on ch2 behind a stalled output word
    mode      = 1'b1;
    out_ready = 1'b0;
    push_tick(2, 8'h5A);
    expect_out("ov pre", 1'b0, 8'h77, 2'd0);
    tick();
    expect_out("ov stall", 1'b1, 8'h5A, 2'd2);
    push_tick(2, 8'hB1);
    push_tick(2, 8'hB2);
    push_tick(2, 8'hB3);
    push_tick(2, 8'hB4);
    check("ov full no flag", 32'(ovf), 32'd0);
    expect_out("ov held", 1'b1, 8'h5A, 2'd2);
    ovf_clr = 1'b1;
    push_tick(2, 8'hB5);
    ovf_clr = 1'b0;
    check("ov set wins", 32'(ovf), 32'h4);
    push_tick(2, 8'hB6);
    check("ov sticky", 32'(ovf), 32'h4);
    out_ready = 1'b1;
    tick();
    expect_out("ov out1", 1'b1, 8'hB1, 2'd2);
    tick();
    expect_out("ov out2", 1'b1, 8'hB2, 2'd2);
    tick();
    expect_out("ov out3", 1'b1, 8'hB3, 2'd2);
    tick();
    expect_out("ov out4", 1'b1, 8'hB4, 2'd2);
    tick();
    expect_out("ov drained", 1'b0, 8'hB4, 2'd0);
    check("ov kept", 32'(ovf), 32'h4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ov clear", 32'(ovf), 32'd0);

    // Full ch0 with simultaneous push and pop; stall stability
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b0;
    push_tick(0, 8'hC0);
    expect_out("fp pre", 1'b0, 8'hB4, 2'd0);
    push_tick(0, 8'hC1);
    expect_out("fp load", 1'b1, 8'hC0, 2'd0);
    push_tick(0, 8'hC2);
    push_tick(0, 8'hC3);
    push_tick(0, 8'hC4);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("stall%0d", i), 1'b1, 8'hC0, 2'd0);
    end
    check("fp full no ovf", 32'(ovf), 32'd0);
    out_ready = 1'b1;
    push_tick(0, 8'hC5);
    expect_out("fp pop", 1'b1, 8'hC1, 2'd0);
    check("fp push+pop no ovf", 32'(ovf), 32'd0);
    tick();
    expect_out("fp d2", 1'b1, 8'hC2, 2'd0);
    tick();
    expect_out("fp d3", 1'b1, 8'hC3, 2'd0);
    tick();
    expect_out("fp d4", 1'b1, 8'hC4, 2'd0);
    tick();
    expect_out("fp d5", 1'b1, 8'hC5, 2'd0);
    tick();
    expect_out("fp empty", 1'b0, 8'hC5, 2'd0);

    // Reset with buffered bytes
    sel       = 2'd1;
    out_ready = 1'b0;
    push_tick(1, 8'hD0);
    push_tick(1, 8'hD1);
    push_tick(1, 8'hD2);
    push_tick(1, 8'hD3);
    expect_out("rs before", 1'b1, 8'hD0, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("rs async", 1'b0, 8'h01, 2'd0);
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out($sformatf("rs stale%0d", i), 1'b0, 8'h01, 2'd0);
    end
    push_tick(1, 8'hE0);
    expect_out("rs fresh pre", 1'b0, 8'h01, 2'd0);
    tick();
    expect_out("rs fresh", 1'b1, 8'hE0, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
